seven_seg_scanner: RTL

Parametrised multi-digit seven-segment display driver and next generation of the one-hot hex decoder. Accepts NUM_DIGITS packed hex nibbles and time-multiplexes them onto one shared segment bus with per-digit anode enables. Decodes each nibble to 7-segment glyphs 0-F and double-buffers new values so they change only at frame boundaries, which prevents display tearing. Sits between datapath and board-level display pins.

---
 rtl/seven_seg_scanner_if.sv | 26 ++
 rtl/seven_seg_scanner.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - input/output bundle between a datapath and the seven-segment scanner
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;
    logic                    pending;
    logic                    frame_done;

    modport master (
        output enable, load, value_in, dp_in,
        input  seg, dp, an, digit_idx, pending, frame_done
    );

    modport slave (
        input  enable, load, value_in, dp_in,
        output seg, dp, an, digit_idx, pending, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed hex display driver with frame-synchronous double buffering
// Optional macro LEADING_ZERO_BLANK_EN blanks segments of digits above the most significant non-zero nibble.
module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic                clk,
    input logic                rst,
    seven_seg_scanner_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]       LAST_PS  = PS_W'(REFRESH_DIV - 1);
    localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    logic [PS_W-1:0]       ps_q, ps_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [VAL_W-1:0]      pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;

    logic                  tick;
    logic                  boundary;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [IDX_W-1:0]      msd_idx;
    logic                  blank;
    logic [6:0]            glyph;

    // Scan timing: prescaler and digit index only move while enabled.
    always_comb begin
        tick     = bus.enable && (ps_q == LAST_PS);
        boundary = tick && (idx_q == LAST_IDX);
        ps_d     = ps_q;
        idx_d    = idx_q;
        if (bus.enable) begin
            if (tick) begin
                ps_d  = '0;
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end else begin
                ps_d  = ps_q + 1'b1;
            end
        end
    end

    // A load that coincides with the boundary bypasses the pending buffer entirely.
    always_comb begin
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pending_d  = pending_q;
        if (boundary) begin
            pending_d = 1'b0;
            if (bus.load) begin
                disp_val_d = bus.value_in;
                disp_dp_d  = bus.dp_in;
            end else if (pending_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
        end else if (bus.load) begin
            pend_val_d = bus.value_in;
            pend_dp_d  = bus.dp_in;
            pending_d  = 1'b1;
        end
        frame_done_d = boundary;
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        an_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib      = disp_val_q[4*k +: 4];
                cur_dp       = disp_dp_q[k];
                an_onehot[k] = 1'b1;
            end
        end
    end

    // Digit 0 is never above the most significant digit, so an all-zero value still shows "0".
    always_comb begin
        msd_idx = '0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (disp_val_q[4*k +: 4] != 4'h0) begin
                msd_idx = IDX_W'(k);
            end
        end
        blank = (idx_q > msd_idx);
`else
        blank = 1'b0;
`endif
    end

    always_comb begin
        glyph       = hex_glyph(cur_nib);
        seg_d       = SEG_OFF;
        dp_d        = DP_OFF;
        an_d        = AN_OFF;
        digit_idx_d = idx_q;
        if (bus.enable) begin
            seg_d = blank ? SEG_OFF : (SEG_ACTIVE_LOW ? ~glyph : glyph);
            dp_d  = SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
            an_d  = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q         <= '0;
            idx_q        <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            digit_idx_q  <= '0;
        end else begin
            ps_q         <= ps_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            digit_idx_q  <= digit_idx_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.digit_idx  = digit_idx_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;
endmodule
